// File: rtl/ysyx_25030077_pkg.sv
// Shared encodings for the trap controller: RV32I opcodes, trap instruction
// words, FSM states and trap causes.
package ysyx_25030077_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef enum logic {
    CAUSE_BREAK   = 1'b0,
    CAUSE_ILLEGAL = 1'b1
  } cause_e;

endpackage

// File: rtl/ysyx_25030077_inst_legal.sv
// Combinational RV32I legality check; ebreak and ecall are the only legal
// SYSTEM encodings.
module ysyx_25030077_inst_legal
  import ysyx_25030077_pkg::*;
(
  input  logic [31:0] inst,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:     legal = (funct3 == 3'b000);
      OPC_BRANCH:   legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_LOAD:     legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                            (funct3 == 3'b010) || (funct3 == 3'b100) ||
                            (funct3 == 3'b101);
      OPC_STORE:    legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                            (funct3 == 3'b010);
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      // SUB and SRA are the only alternate-funct7 OP encodings
      OPC_OP:       legal = (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OPC_MISC_MEM: legal = 1'b1;
      OPC_SYSTEM:   legal = (inst == INST_ECALL) || (inst == INST_EBREAK);
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030077_trap_ctrl.sv
// Trap controller: catches ebreak / illegal instructions at retire, drains
// outstanding memory traffic, reports the cause once and halts the core.
//
// state  | meaning
// RUN    | normal execution, watching retiring instructions
// DRAIN  | trap latched, waiting for min cycles and lsu idle
// REPORT | single cycle, cause pulse is high
// HALT   | core stopped until reset
module ysyx_25030077_trap_ctrl
  import ysyx_25030077_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] a0,
  input  logic        lsu_busy,
  output logic        stall,
  output logic        is_break_out,
  output logic        is_unknown_instruction,
  output logic        halted,
  output logic [31:0] halt_pc,
  output logic [31:0] halt_code
);

  localparam logic [3:0] DRAIN_THRESH = DRAIN_CYCLES[3:0];

  state_e     state, state_nxt;
  cause_e     cause;
  logic [3:0] drain_cnt;
  logic [3:0] drain_cnt_inc;
  logic       legal;
  logic       is_ebreak;
  logic       trap_hit;
  logic       drain_done;
  logic       brk_q;
  logic       ill_q;

  ysyx_25030077_inst_legal u_inst_legal (
    .inst  (inst),
    .legal (legal)
  );

  assign is_ebreak = (inst == INST_EBREAK);
  assign trap_hit  = inst_valid && (is_ebreak || !legal);

  // Exit is judged on the post-increment count so the first DRAIN cycle
  // already counts as one drained cycle.
  assign drain_cnt_inc = (drain_cnt == 4'hF) ? 4'hF : drain_cnt + 4'd1;
  assign drain_done    = (drain_cnt_inc >= DRAIN_THRESH) && !lsu_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (trap_hit) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_HALT;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = (state != ST_RUN) || trap_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= 4'd0;
      cause     <= CAUSE_BREAK;
      halt_pc   <= 32'd0;
      halt_code <= 32'd0;
      brk_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_RUN) && trap_hit) begin
        drain_cnt <= 4'd0;
        cause     <= is_ebreak ? CAUSE_BREAK : CAUSE_ILLEGAL;
        halt_pc   <= pc;
        halt_code <= a0;
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt_inc;
      end
      brk_q <= (state_nxt == ST_REPORT) && (cause == CAUSE_BREAK);
      ill_q <= (state_nxt == ST_REPORT) && (cause == CAUSE_ILLEGAL);
    end
  end

  assign is_break_out           = brk_q;
  assign is_unknown_instruction = ill_q;
  assign halted                 = (state == ST_HALT);

endmodule

// File: tb/tb_ysyx_25030077_trap_ctrl.sv
// Bench for the trap controller: event-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ysyx_25030077_trap_ctrl;

  localparam int D = 2;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] M_OPC  = 32'h0000_007F;
  localparam logic [31:0] M_F3   = 32'h0000_707F;
  localparam logic [31:0] M_F7   = 32'hFE00_007F;
  localparam logic [31:0] M_F73  = 32'hFE00_707F;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] a0;
  logic        lsu_busy;
  logic        stall;
  logic        is_break_out;
  logic        is_unknown_instruction;
  logic        halted;
  logic [31:0] halt_pc;
  logic [31:0] halt_code;

  ysyx_25030077_trap_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .inst_valid             (inst_valid),
    .inst                   (inst),
    .pc                     (pc),
    .a0                     (a0),
    .lsu_busy               (lsu_busy),
    .stall                  (stall),
    .is_break_out           (is_break_out),
    .is_unknown_instruction (is_unknown_instruction),
    .halted                 (halted),
    .halt_pc                (halt_pc),
    .halt_code              (halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int brk_cnt  = 0;
  int ill_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pm(input logic [31:0] w, input logic [31:0] m, input logic [31:0] v);
    return (w & m) == v;
  endfunction

  // Legal instruction set as a list of mask/match patterns.
  function automatic bit m_legal(input logic [31:0] w);
    bit ok = 1'b0;
    for (int f = 0; f < 8; f++) begin
      logic [31:0] f3s;
      f3s = 32'(f) << 12;
      if (f != 2 && f != 3)                      ok |= pm(w, M_F3, 32'h63 | f3s);
      if (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) ok |= pm(w, M_F3, 32'h03 | f3s);
      if (f <= 2)                                ok |= pm(w, M_F3, 32'h23 | f3s);
      if (f != 1 && f != 5)                      ok |= pm(w, M_F3, 32'h13 | f3s);
    end
    ok |= pm(w, M_OPC, 32'h37) | pm(w, M_OPC, 32'h17) | pm(w, M_OPC, 32'h6F);
    ok |= pm(w, M_OPC, 32'h0F) | pm(w, M_F3, 32'h67);
    ok |= pm(w, M_F73, 32'h0000_1013) | pm(w, M_F73, 32'h0000_5013) | pm(w, M_F73, 32'h4000_5013);
    ok |= pm(w, M_F7, 32'h33) | pm(w, M_F73, 32'h4000_0033) | pm(w, M_F73, 32'h4000_5033);
    ok |= (w == 32'h0000_0073) | (w == EBREAK);
    return ok;
  endfunction

  // Model: record trap interval, then pulse interval = first interval at or
  // after trap+max(D,1) with lsu idle, plus one.
  int          cyc       = 0;
  bit          trapped   = 1'b0;
  int          t_trap    = 0;
  int          pulse_cyc = -1;
  bit          m_brk     = 1'b0;
  logic [31:0] m_pc      = 32'd0;
  logic [31:0] m_code    = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      trapped   = 1'b0;
      pulse_cyc = -1;
      m_pc      = 32'd0;
      m_code    = 32'd0;
      m_brk     = 1'b0;
    end else if (!trapped) begin
      if (inst_valid && (inst == EBREAK || !m_legal(inst))) begin
        trapped = 1'b1;
        t_trap  = cyc;
        m_pc    = pc;
        m_code  = a0;
        m_brk   = (inst == EBREAK);
      end
    end else if (pulse_cyc < 0 && cyc >= t_trap + (D > 1 ? D : 1) && !lsu_busy) begin
      pulse_cyc = cyc + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit pulse_now;
      bit exp_stall;
      pulse_now = (pulse_cyc == cyc);
      exp_stall = !reset && (trapped || (inst_valid && (inst == EBREAK || !m_legal(inst))));
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("is_break_out", {31'd0, is_break_out}, {31'd0, pulse_now && m_brk});
      chk("is_unknown_instruction", {31'd0, is_unknown_instruction}, {31'd0, pulse_now && !m_brk});
      chk("halted", {31'd0, halted}, {31'd0, trapped && pulse_cyc >= 0 && cyc > pulse_cyc});
      chk("halt_pc", halt_pc, m_pc);
      chk("halt_code", halt_code, m_code);
      brk_cnt += int'(is_break_out);
      ill_cnt += int'(is_unknown_instruction);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    inst_valid = 1'b0;
    lsu_busy   = 1'b0;
    step();
    step();
    reset   = 1'b0;
    brk_cnt = 0;
    ill_cnt = 0;
  endtask

  task automatic drive_inst(input logic [31:0] w, input logic [31:0] p, input logic [31:0] code);
    inst_valid = 1'b1;
    inst       = w;
    pc         = p;
    a0         = code;
  endtask

  logic [31:0] sweep_inst [5] = '{32'h0000_0013, 32'h4000_5013, 32'h4000_1033, 32'h0000_2067, 32'h0000_0073};
  bit          sweep_ok   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst = 32'h13; pc = 32'd0; a0 = 32'd0; lsu_busy = 1'b0;
    do_reset();
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_halt_pc", halt_pc, 32'd0);

    // ebreak, no lsu traffic: pulse at T+3, halted from T+4
    step();
    drive_inst(EBREAK, 32'h8000_0010, 32'd0);
    @(negedge clk); chk("s1_stall_T", {31'd0, stall}, 32'd1);
    step(); inst_valid = 1'b0;
    step();
    @(negedge clk); chk("s1_brk_T2", {31'd0, is_break_out}, 32'd0);
    step();
    @(negedge clk); chk("s1_brk_T3", {31'd0, is_break_out}, 32'd1);
    chk("s1_halted_T3", {31'd0, halted}, 32'd0);
    step();
    @(negedge clk); chk("s1_halted_T4", {31'd0, halted}, 32'd1);
    chk("s1_halt_pc", halt_pc, 32'h8000_0010);
    chk("s1_halt_code", halt_code, 32'd0);
    repeat (3) step();
    chk("s1_brk_count", brk_cnt, 32'd1);

    // illegal word
    do_reset();
    drive_inst(32'hFFFF_FFFF, 32'h8000_0024, 32'd1);
    step(); inst_valid = 1'b0;
    repeat (6) step();
    chk("s2_ill_count", ill_cnt, 32'd1);
    chk("s2_brk_count", brk_cnt, 32'd0);
    chk("s2_halt_code", halt_code, 32'd1);
    chk("s2_halt_pc", halt_pc, 32'h8000_0024);

    // lsu busy over T+1..T+5 delays pulse to T+7
    do_reset();
    drive_inst(EBREAK, 32'h8000_0040, 32'd7);
    step(); inst_valid = 1'b0; lsu_busy = 1'b1;
    repeat (4) step();
    step(); lsu_busy = 1'b0;
    @(negedge clk); chk("s3_brk_T6", {31'd0, is_break_out}, 32'd0);
    step();
    @(negedge clk); chk("s3_brk_T7", {31'd0, is_break_out}, 32'd1);
    repeat (2) step();
    chk("s3_brk_count", brk_cnt, 32'd1);

    // legality sweep, observed on stall while in RUN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      drive_inst(sweep_inst[i], 32'h8000_0100, 32'd0);
      @(negedge clk);
      chk("s4_model_legal", {31'd0, m_legal(sweep_inst[i])}, {31'd0, sweep_ok[i]});
      chk("s4_stall", {31'd0, stall}, {31'd0, !sweep_ok[i]});
      #1 inst_valid = 1'b0;
    end

    // reset in DRAIN, with a trapping instruction during reset
    do_reset();
    drive_inst(EBREAK, 32'h8000_0100, 32'd5);
    step(); inst_valid = 1'b0;
    step(); reset = 1'b1; drive_inst(32'hFFFF_FFFF, 32'h8000_0300, 32'd9);
    @(negedge clk); chk("s5_stall_in_reset", {31'd0, stall}, 32'd0);
    step(); reset = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    chk("s5_halt_code_cleared", halt_code, 32'd0);
    chk("s5_halt_pc_cleared", halt_pc, 32'd0);
    chk("s5_stall_cleared", {31'd0, stall}, 32'd0);
    step();
    drive_inst(EBREAK, 32'h8000_0200, 32'h2A);
    step(); inst_valid = 1'b0;
    repeat (6) step();
    chk("s5_brk_count", brk_cnt, 32'd1);
    chk("s5_ill_count", ill_cnt, 32'd0);
    chk("s5_halt_code", halt_code, 32'h2A);
    chk("s5_halt_pc", halt_pc, 32'h8000_0200);

    // HALT ignores further traps
    for (int i = 0; i < 20; i++) begin
      step();
      drive_inst((i % 2 == 0) ? EBREAK : 32'hFFFF_FFFF, 32'(i), 32'(i + 100));
    end
    step(); inst_valid = 1'b0;
    chk("s6_brk_count", brk_cnt, 32'd1);
    chk("s6_ill_count", ill_cnt, 32'd0);
    chk("s6_halt_code", halt_code, 32'h2A);
    chk("s6_halt_pc", halt_pc, 32'h8000_0200);
    chk("s6_halted", {31'd0, halted}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
